// File: rtl/local_bias_pkg.sv
// Purpose : shared types and constants for the local bias sequencer slice.
// Latency : n/a (declarations only).
// Backpress: n/a.
package local_bias_pkg;

    // Encoding is visible on state_o for debug, so the values are pinned.
    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_WAIT_SUP = 3'd1,
        ST_RAMP     = 3'd2,
        ST_READY    = 3'd3,
        ST_FAULT    = 3'd4
    } state_e;

    localparam int                FCNT_W   = 8;
    localparam logic [FCNT_W-1:0] FCNT_MAX = '1;

    // ATB line enable encoding: bit1 drives atb1, bit0 drives atb0.
    localparam logic [1:0] ATB_NONE  = 2'b00;
    localparam logic [1:0] ATB_LINE0 = 2'b01;
    localparam logic [1:0] ATB_LINE1 = 2'b10;
    localparam logic [1:0] ATB_BOTH  = 2'b11;

endpackage

// File: rtl/local_bias_seq_if.sv
// Purpose : control/status bundle between power management and the bias sequencer.
// Latency : n/a (wiring only).
// Backpress: none; level signals only.
// Ports   : master = power-management side (drives pdb, supply flags, enables, ATB select),
//           slave  = sequencer side (drives bias_en, ready, fault status, ATB switch controls).
interface local_bias_seq_if #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
);
    import local_bias_pkg::*;

    logic              pdb;
    logic              sup_1p8_ok;
    logic              sup_0p8_ok;
    logic              sup_vss_ok;
    logic [N_CH-1:0]   ch_en;
    logic [1:0]        atb_ena;
    logic [CH_W-1:0]   atb_ch;

    logic [N_CH-1:0]   bias_en;
    logic              ready;
    logic              fault;
    logic [FCNT_W-1:0] fault_cnt;
    logic [N_CH-1:0]   atb_route;
    logic [1:0]        atb_bus_en;
    logic [2:0]        state_o;

    modport master (
        output pdb, sup_1p8_ok, sup_0p8_ok, sup_vss_ok, ch_en, atb_ena, atb_ch,
        input  bias_en, ready, fault, fault_cnt, atb_route, atb_bus_en, state_o
    );

    modport slave (
        input  pdb, sup_1p8_ok, sup_0p8_ok, sup_vss_ok, ch_en, atb_ena, atb_ch,
        output bias_en, ready, fault, fault_cnt, atb_route, atb_bus_en, state_o
    );

endinterface

// File: rtl/local_bias_debounce.sv
// Purpose : supply-good filter; sup_good only after DEBOUNCE_CYC consecutive good samples.
// Latency : rises DEBOUNCE_CYC edges after sup_raw rises, falls 1 edge after sup_raw falls.
// Backpress: none.
// Ports   : clk, rst_n (async active-low), sup_raw in, sup_good out.
module local_bias_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sup_raw,
    output logic sup_good
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);

    logic [DW-1:0] cnt;

    // Counter saturates at DEBOUNCE_CYC; any bad sample restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!sup_raw) begin
            cnt <= '0;
        end else if (cnt != DW'(DEBOUNCE_CYC)) begin
            cnt <= cnt + DW'(1);
        end
    end

    assign sup_good = (cnt == DW'(DEBOUNCE_CYC));

endmodule

// File: rtl/local_bias_seq.sv
// Purpose : power-up sequencer and ATB router for N_CH local bias channels.
// Latency : one channel enabled per slot (SETTLE_CYC hold after enable); ATB controls 1 cycle.
// Backpress: none; supply loss forces FAULT, pdb low forces OFF with priority.
// Ports   : clk, rst_n (async active-low), bus (local_bias_seq_if.slave).
module local_bias_seq
    import local_bias_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int SETTLE_CYC   = 16,
    parameter int DEBOUNCE_CYC = 4,
    parameter int CH_W         = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    local_bias_seq_if.slave         bus
);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    state_e            state, state_n;
    logic [CH_W-1:0]   idx, idx_n;
    logic [SW-1:0]     settle, settle_n;
    logic [N_CH-1:0]   bias_en, bias_n;
    logic              fault, fault_n;
    logic [FCNT_W-1:0] fault_cnt, fcnt_n;
    logic [N_CH-1:0]   atb_route, route_n;
    logic [1:0]        atb_bus_en;
    logic              sup_raw;
    logic              sup_good;
    logic              advance;

    assign sup_raw = bus.sup_1p8_ok & bus.sup_0p8_ok & bus.sup_vss_ok;

    local_bias_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .sup_raw  (sup_raw),
        .sup_good (sup_good)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            idx       <= '0;
            settle    <= '0;
            bias_en   <= '0;
            fault     <= 1'b0;
            fault_cnt <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            settle    <= settle_n;
            bias_en   <= bias_n;
            fault     <= fault_n;
            fault_cnt <= fcnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        settle_n = settle;
        bias_n   = bias_en;
        fault_n  = fault;
        fcnt_n   = fault_cnt;
        advance  = 1'b0;

        if (!bus.pdb) begin
            // Power-down wins over a simultaneous supply loss: no fault recorded.
            state_n  = ST_OFF;
            idx_n    = '0;
            settle_n = '0;
            bias_n   = '0;
            fault_n  = 1'b0;
        end else if ((state == ST_RAMP || state == ST_READY) && !sup_raw) begin
            // Raw flag, not the debounced one, so bias drops on the first bad sample.
            state_n = ST_FAULT;
            bias_n  = '0;
            fault_n = 1'b1;
            if (fault_cnt != FCNT_MAX) begin
                fcnt_n = fault_cnt + FCNT_W'(1);
            end
        end else begin
            case (state)
                ST_OFF: begin
                    bias_n  = '0;
                    state_n = ST_WAIT_SUP;
                end
                ST_WAIT_SUP: begin
                    bias_n = '0;
                    if (sup_good) begin
                        state_n  = ST_RAMP;
                        idx_n    = '0;
                        settle_n = '0;
                    end
                end
                ST_RAMP: begin
                    bias_n = bias_en & bus.ch_en;
                    // settle != 0 means the current channel was just enabled and is
                    // still ramping; the slot ends on the edge where it reaches 1.
                    if (settle != '0) begin
                        settle_n = settle - SW'(1);
                        advance  = (settle == SW'(1));
                    end else if (bus.ch_en[idx] && !bias_en[idx]) begin
                        bias_n[idx] = 1'b1;
                        settle_n    = SW'(SETTLE_CYC);
                    end else begin
                        advance = 1'b1;
                    end
                    if (advance) begin
                        if (idx == CH_W'(N_CH - 1)) begin
                            state_n = ST_READY;
                        end else begin
                            idx_n = idx + CH_W'(1);
                        end
                    end
                end
                ST_READY: begin
                    bias_n = bias_en & bus.ch_en;
                    // Newly requested channel: restart the walk; enabled ones skip in 1 cycle.
                    if (|(bus.ch_en & ~bias_en)) begin
                        state_n  = ST_RAMP;
                        idx_n    = '0;
                        settle_n = '0;
                    end
                end
                ST_FAULT: begin
                    bias_n = '0;
                end
                default: begin
                    state_n = ST_OFF;
                    bias_n  = '0;
                end
            endcase
        end
    end

    // ATB switch: route only a live, in-range channel; the per-index compare
    // naturally routes nothing for atb_ch >= N_CH.
    always_comb begin
        route_n = '0;
        for (int i = 0; i < N_CH; i++) begin
            route_n[i] = (bus.atb_ch == CH_W'(i)) && bias_en[i] && (bus.atb_ena != ATB_NONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            atb_route  <= '0;
            atb_bus_en <= ATB_NONE;
        end else begin
            atb_route  <= route_n;
            atb_bus_en <= (|route_n) ? bus.atb_ena : ATB_NONE;
        end
    end

    assign bus.bias_en    = bias_en;
    assign bus.ready      = (state == ST_READY);
    assign bus.fault      = fault;
    assign bus.fault_cnt  = fault_cnt;
    assign bus.atb_route  = atb_route;
    assign bus.atb_bus_en = atb_bus_en;
    assign bus.state_o    = state;

endmodule
